// File: rtl/fir_mac_sched.sv
// fir_mac_sched: 6-tap FIR that walks the taps through one shared multiplier.
// Define FIR_SAT_EN to saturate the output to DATA_W instead of wrapping.
module fir_mac_sched #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 16,
    parameter int FRAC_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              coef_we,
    input  logic [2:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              coef_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_11,
    input  logic              out_ready,
    output logic              busy
);
    localparam int NTAP   = 6;
    localparam int ACC_W  = 52;
    localparam int PROD_W = DATA_W + COEF_W;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_tap  [NTAP];  // r_tap[0] is in_1_0 (newest), r_tap[5] is in_6_0
    logic signed [COEF_W-1:0] r_coef [NTAP];
    logic signed [ACC_W-1:0]  r_acc;
    logic [2:0]               r_k;
    logic                     r_in_ready;
    logic                     r_busy;
    logic                     r_out_valid;
    logic                     r_coef_err;
    logic [DATA_W-1:0]        r_out;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic [DATA_W-1:0]        w_out;
    logic                     w_coef_ok;

    assign w_prod    = r_tap[r_k] * r_coef[r_k];
    assign w_acc_nxt = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_coef_ok = (r_state == IDLE) && (coef_addr < 3'd6);

`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] w_shift;
    logic                    w_fit;
    assign w_shift = w_acc_nxt >>> FRAC_W;
    // fits when every bit above the DATA_W sign bit matches it
    assign w_fit   = (&w_shift[ACC_W-1:DATA_W-1]) | ~(|w_shift[ACC_W-1:DATA_W-1]);
    assign w_out   = w_fit ? w_shift[DATA_W-1:0] :
                     (w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
`else
    assign w_out   = w_acc_nxt[FRAC_W +: DATA_W];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_coef_err  <= 1'b0;
            r_out       <= '0;
            for (int i = 0; i < NTAP; i++) begin
                r_tap[i]  <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            r_coef_err <= coef_we && !w_coef_ok;
            if (coef_we && w_coef_ok)
                r_coef[coef_addr] <= coef_wdata;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_tap[0] <= in_data;
                    for (int i = 1; i < NTAP; i++)
                        r_tap[i] <= r_tap[i-1];
                    r_acc      <= '0;
                    r_k        <= '0;
                    r_state    <= MAC;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
                MAC: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= r_k + 3'd1;
                    // result is taken from the final sum so it appears on OUT entry
                    if (r_k == 3'd5) begin
                        r_state     <= OUT;
                        r_out       <= w_out;
                        r_out_valid <= 1'b1;
                    end
                end
                OUT: if (out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_11    = r_out;
    assign coef_err  = r_coef_err;
endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: impulse, window, saturation, backpressure, rejects, reset.
module tb_fir_mac_sched;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, coef_we = 1'b0, out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        in_ready, coef_err, out_valid, busy;
    logic [31:0] out_11;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    fir_mac_sched dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
        .out_valid(out_valid), .out_11(out_11), .out_ready(out_ready), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic wcoef(input logic [2:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        step();
        coef_we = 1'b0;
    endtask

    task automatic wait_out(output logic [31:0] res, output int n);
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
        res = out_11;
    endtask

    task automatic send(input logic [31:0] d, output logic [31:0] res, output int lat);
        int n = 0;
        while (!in_ready && n < 30) begin step(); n++; end
        chk("in_ready_seen", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
        wait_out(res, n);
        lat = n + 1;
    endtask

    initial begin
        logic [31:0] res;
        int          lat, seen;
        int          exp_fw [6] = '{1, 3, 6, 10, 15, 21};

        // reset state
        do_reset();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_11", {32'd0, out_11}, 64'd0);
        chk("rst_coef_err", {63'd0, coef_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // impulse
        wcoef(3'd0, 16'h4000);
        chk("valid_wr_no_err", {63'd0, coef_err}, 64'd0);
        send(32'd1000, res, lat);
        chk("imp_latency", 64'(lat), 64'd7);
        chk("imp_result", {32'd0, res}, 64'd500);
        step();
        chk("imp_ov_drop", {63'd0, out_valid}, 64'd0);
        chk("imp_idle", {63'd0, busy}, 64'd0);

        // full window, all taps 0.5
        do_reset();
        for (int i = 0; i < 6; i++) wcoef(3'(i), 16'h4000);
        for (int i = 0; i < 6; i++) begin
            send(32'(2 * (i + 1)), res, lat);
            chk($sformatf("fw_res%0d", i), {32'd0, res}, 64'(exp_fw[i]));
        end

        // positive overflow
        do_reset();
        for (int i = 0; i < 6; i++) wcoef(3'(i), 16'h7FFF);
        for (int i = 0; i < 6; i++) begin
            send(32'h7FFF_FFFF, res, lat);
            if (i == 0) chk("sat_res0", {32'd0, res}, 64'h7FFE_FFFF);
`ifdef FIR_SAT_EN
            if (i == 1) chk("sat_res1", {32'd0, res}, 64'h7FFF_FFFF);
            if (i == 5) chk("sat_res5", {32'd0, res}, 64'h7FFF_FFFF);
`else
            if (i == 1) chk("wrap_res1", {32'd0, res}, 64'hFFFD_FFFE);
            if (i == 5) chk("wrap_res5", {32'd0, res}, 64'hFFF9_FFFA);
`endif
        end

        // negative overflow
        do_reset();
        wcoef(3'd0, 16'h7FFF);
        wcoef(3'd1, 16'h7FFF);
        send(32'h8000_0000, res, lat);
        chk("neg_res0", {32'd0, res}, 64'h8001_0000);
        send(32'h8000_0000, res, lat);
`ifdef FIR_SAT_EN
        chk("neg_sat_res1", {32'd0, res}, 64'h8000_0000);
`else
        chk("neg_wrap_res1", {32'd0, res}, 64'h0002_0000);
`endif

        // backpressure with in_valid held high
        do_reset();
        wcoef(3'd0, 16'h4000);
        wcoef(3'd1, 16'h4000);
        out_ready = 1'b0;
        send(32'd100, res, lat);
        chk("bp_first", {32'd0, res}, 64'd50);
        in_valid = 1'b1; in_data = 32'd777;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_ov%0d", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp_out%0d", i), {32'd0, out_11}, 64'd50);
            chk($sformatf("bp_rdy%0d", i), {63'd0, in_ready}, 64'd0);
            step();
        end
        chk("bp_tap0", 64'(dut.r_tap[0]), 64'd100);
        chk("bp_tap1", 64'(dut.r_tap[1]), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_idle_busy", {63'd0, busy}, 64'd0);
        chk("bp_idle_rdy", {63'd0, in_ready}, 64'd1);
        chk("bp_idle_ov", {63'd0, out_valid}, 64'd0);
        step();
        in_valid = 1'b0;
        wait_out(res, lat);
        chk("bp_next", {32'd0, res}, 64'd438);
        chk("bp_tap1_after", 64'(dut.r_tap[1]), 64'd100);

        // rejected writes
        do_reset();
        wcoef(3'd0, 16'h4000);
        in_valid = 1'b1; in_data = 32'd1000;
        step();
        in_valid = 1'b0;
        step(); step();
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h7FFF;
        step();
        coef_we = 1'b0;
        chk("rej_mac_err", {63'd0, coef_err}, 64'd1);
        step();
        chk("rej_mac_err_end", {63'd0, coef_err}, 64'd0);
        wait_out(res, lat);
        chk("rej_mac_res", {32'd0, res}, 64'd500);
        chk("rej_coef0", 64'(dut.r_coef[0]), 64'h4000);
        step();
        wcoef(3'd6, 16'h7FFF);
        chk("rej_addr_err", {63'd0, coef_err}, 64'd1);
        step();
        chk("rej_addr_err_end", {63'd0, coef_err}, 64'd0);
        send(32'd1000, res, lat);
        chk("rej_addr_res", {32'd0, res}, 64'd500);

        // reset in the middle of MAC
        do_reset();
        wcoef(3'd0, 16'h4000);
        in_valid = 1'b1; in_data = 32'd1000;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1;
            step();
        end
        chk("mr_no_ov", 64'(seen), 64'd0);
        chk("mr_tap0", 64'(dut.r_tap[0]), 64'd0);
        chk("mr_coef0", 64'(dut.r_coef[0]), 64'd0);
        wcoef(3'd0, 16'h4000);
        send(32'd1000, res, lat);
        chk("mr_res", {32'd0, res}, 64'd500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
